// File: rtl/fp32_pkg.sv
// fp32_pkg: shared fp32 field widths, constants and FPU sequencer states.
package fp32_pkg;
  localparam int SIGN_W = 1;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam int EXP_BIAS = 127;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  typedef enum logic [1:0] {IDLE, DIV, NORM} state_t;
endpackage

// File: rtl/fp32_classify.sv
// fp32_classify: splits one fp32 operand into fields and flags zero (denormals flushed) and Inf/NaN.
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [SIGN_W+EXP_W+FRAC_W-1:0] x,
  output logic                           sign,
  output logic [EXP_W-1:0]               expo,
  output logic [FRAC_W-1:0]              frac,
  output logic                           is_zero,
  output logic                           is_special
);
  assign {sign, expo, frac} = x;
  assign is_zero = expo == '0;
  assign is_special = &expo;
endmodule

// File: rtl/fdiv_seq.sv
// fdiv_seq: iterative fp32 divider, restoring division one quotient bit per clock, truncating.
module fdiv_seq
  import fp32_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);
  state_t state, state_nxt;
  logic sa, sb, za, zb, xa, xb;
  logic [EXP_W-1:0] ea_in, eb_in, ea, eb;
  logic [FRAC_W-1:0] fa_in, fb_in, frac;
  logic sign_r, accept, special, ge;
  logic [FRAC_W+2:0] rem;
  logic [FRAC_W:0] dvs;
  logic [ITER-1:0] q;
  logic [4:0] cnt;
  logic signed [9:0] e;
  logic [WIDTH-1:0] spec_out, norm_out;
  fp32_classify u_ca (.x(a), .sign(sa), .expo(ea_in), .frac(fa_in), .is_zero(za), .is_special(xa));
  fp32_classify u_cb (.x(b), .sign(sb), .expo(eb_in), .frac(fb_in), .is_zero(zb), .is_special(xb));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (accept && !special ? DIV : IDLE) :
                state == DIV  ? (cnt == 0 ? NORM : DIV) : IDLE;
  always_comb begin
    busy = state != IDLE;
    accept = start && state == IDLE;
    special = xa || xb || za || zb;
    spec_out = (xa || xb || (za && zb)) ? QNAN :
               zb ? {sa ^ sb, EXP_MAX, {FRAC_W{1'b0}}} : {sa ^ sb, {WIDTH-1{1'b0}}};
    ge = rem >= {2'b0, dvs};
    frac = q[ITER-1] ? q[ITER-2:1] : q[ITER-3:0];
    e = $signed({2'b0, ea}) - $signed({2'b0, eb}) + $signed(10'(q[ITER-1] ? EXP_BIAS : EXP_BIAS - 1));
    norm_out = e <= 10'sd0   ? {sign_r, {WIDTH-1{1'b0}}} :
               e >= 10'sd255 ? {sign_r, EXP_MAX, {FRAC_W{1'b0}}} : {sign_r, e[EXP_W-1:0], frac};
  end
  // Datapath: operands latch on acceptance; the remainder keeps two spare bits so it never overflows.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sign_r <= 1'b0;
      ea <= '0;
      eb <= '0;
      rem <= '0;
      dvs <= '0;
      q <= '0;
      cnt <= '0;
    end else if (accept && !special) begin
      sign_r <= sa ^ sb;
      ea <= ea_in;
      eb <= eb_in;
      rem <= {2'b01, fa_in};
      dvs <= {1'b1, fb_in};
      q <= '0;
      cnt <= 5'(ITER - 1);
    end else if (state == DIV) begin
      q[cnt] <= ge;
      rem <= (ge ? rem - {2'b0, dvs} : rem) << 1;
      cnt <= cnt == 0 ? 5'd0 : cnt - 5'd1;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out <= '0;
      done <= 1'b0;
    end else begin
      done <= (accept && special) || state == NORM;
      if (accept && special) out <= spec_out;
      else if (state == NORM) out <= norm_out;
    end
endmodule

// File: tb/tb_fdiv_seq.sv
// tb_fdiv_seq: directed vectors for fdiv_seq, covering latency, specials, range limits, handshake and reset.
module tb_fdiv_seq;
  logic clk = 0, rst_n = 0, start = 0, busy, done;
  logic [31:0] a = 0, b = 0, out;
  int total = 0, bad = 0;
  int lat, bc;
  fdiv_seq dut (.clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .busy(busy), .done(done), .out(out));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // lat counts edges after the accepting edge until done is seen; poke re-pulses start mid-operation.
  task automatic do_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] exp_out, input int exp_lat, input int poke);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    lat = 0;
    bc = 0;
    while (!done && lat < 40) begin
      bc += int'(busy);
      @(posedge clk);
      #1 lat++;
      start = lat == poke;
      if (lat == poke) a = 32'h3F80_0000;
    end
    start = 0;
    check({tag, ".out"}, out, exp_out);
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".busy_cyc"}, bc, exp_lat);
    check({tag, ".busy_at_done"}, {31'b0, busy}, 0);
  endtask
  initial begin
    #12;
    check("rst.out", out, 0);
    check("rst.done", {31'b0, done}, 0);
    check("rst.busy", {31'b0, busy}, 0);
    @(negedge clk) rst_n = 1;
    do_op("div6_2", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 26, -1);
    @(posedge clk);
    #1 check("done_pulse", {31'b0, done}, 0);
    repeat (3) @(posedge clk);
    #1 check("out_held", out, 32'h4040_0000);
    do_op("div1_3", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 26, -1);
    do_op("divm1_3", 32'hBF80_0000, 32'h4040_0000, 32'hBEAA_AAAA, 26, -1);
    do_op("zero_a", 32'h0000_0000, 32'h40A0_0000, 32'h0000_0000, 0, -1);
    @(posedge clk);
    #1 check("spec_pulse", {31'b0, done}, 0);
    do_op("div_by0", 32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 0, -1);
    do_op("zero_zero", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 0, -1);
    do_op("inf_a", 32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 0, -1);
    do_op("underflow", 32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 26, -1);
    do_op("overflow", 32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 26, -1);
    do_op("ignore_start", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 26, 10);
    do_op("b2b_first", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 26, -1);
    do_op("b2b_second", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 26, -1);
    @(negedge clk);
    a = 32'h40C0_0000;
    b = 32'h4000_0000;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (12) @(posedge clk);
    #1 rst_n = 0;
    #1;
    check("mid_rst.out", out, 0);
    check("mid_rst.busy", {31'b0, busy}, 0);
    check("mid_rst.done", {31'b0, done}, 0);
    @(negedge clk) rst_n = 1;
    lat = 0;
    repeat (30) begin
      @(negedge clk);
      lat += int'(done);
    end
    check("mid_rst.no_done", lat, 0);
    do_op("after_rst", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 26, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
